fighter_motion: RTL and testbench

Per-fighter movement engine. One instance runs per character, upstream of the game control block. It converts keyboard keycodes into on-screen position, applying walk, jump/double-jump, gravity, stage landing and hit knockback. It detects ring-out, drives the death pulse and respawns the fighter. Its pos_x/pos_y/death outputs feed the control block's c*x/c*y/death_c* inputs; the control block's hp and hit_on outputs feed back into hp/hit_in.

---
 rtl/fighter_motion.sv | 240 ++++++++++++++++++++++++
 tb/tb_fighter_motion.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/fighter_motion.sv
// Per-fighter movement engine: turns keycodes into walk/jump/gravity motion with
// stage landing, hit knockback, ring-out detection and a timed respawn.
module fighter_motion #(
    parameter logic [7:0] KEY_LEFT       = 8'h04,
    parameter logic [7:0] KEY_RIGHT      = 8'h07,
    parameter logic [7:0] KEY_JUMP       = 8'h1A,
    parameter int         SPAWN_X        = 200,
    parameter int         SPAWN_Y        = 100,
    parameter int         GROUND_Y       = 380,
    parameter int         STAGE_X_MIN    = 80,
    parameter int         STAGE_X_MAX    = 520,
    parameter int         WALK_V         = 2,
    parameter int         JUMP_V         = 12,
    parameter int         MAX_FALL       = 8,
    parameter int         KB_BASE        = 4,
    parameter int         KB_SHIFT       = 3,
    parameter int         KB_MAX         = 24,
    parameter int         RESPAWN_FRAMES = 60
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        frame_tick,
    input  logic        enable,
    input  logic [7:0]  keycode_1,
    input  logic [7:0]  keycode_2,
    input  logic [7:0]  keycode_3,
    input  logic [7:0]  keycode_4,
    input  logic [11:0] hp,
    input  logic        hit_in,
    input  logic [9:0]  opp_x,
    output logic [9:0]  pos_x,
    output logic [9:0]  pos_y,
    output logic        death,
    output logic        on_ground,
    output logic        facing
);
    typedef enum logic [1:0] {IDLE, AIR, GROUND, DEAD} state_t;

    localparam int CW = $clog2(RESPAWN_FRAMES + 1);
    localparam logic signed [11:0] SPX   = 12'(SPAWN_X);
    localparam logic signed [11:0] SPY   = 12'(SPAWN_Y);
    localparam logic signed [11:0] GY    = 12'(GROUND_Y);
    localparam logic signed [11:0] XMIN  = 12'(STAGE_X_MIN);
    localparam logic signed [11:0] XMAX  = 12'(STAGE_X_MAX);
    localparam logic signed [11:0] XLIM  = 12'sd639;
    localparam logic signed [11:0] YLIM  = 12'sd479;
    localparam logic signed [7:0]  WALK  = 8'(WALK_V);
    localparam logic signed [7:0]  JUMP  = 8'(JUMP_V);
    localparam logic signed [7:0]  FALL  = 8'(MAX_FALL);
    localparam logic [CW-1:0]      CLAST = CW'(RESPAWN_FRAMES - 1);

    state_t               state_q, state_d;
    logic signed [11:0]   x_q, x_d, y_q, y_d;
    logic signed [7:0]    vy_q, vy_d, kb_q, kb_d;
    logic                 air_jumps_q, air_jumps_d;
    logic                 facing_q, facing_d;
    logic                 jump_prev_q, jump_prev_d;
    logic                 hit_prev_q, hit_prev_d;
    logic                 death_q, death_d;
    logic                 on_ground_q, on_ground_d;
    logic [CW-1:0]        cnt_q, cnt_d;

    logic                 key_l, key_r, key_j;
    logic signed [7:0]    vx_cmd;
    logic [12:0]          kb_sum;
    logic signed [7:0]    kb_mag;
    logic                 x_ge_opp;

    state_t               st_c;
    logic signed [7:0]    vy_c, kb_c;
    logic                 aj_c;
    logic signed [11:0]   x_nx, y_nx;

    function automatic logic signed [11:0] sx(input logic signed [7:0] v);
        return {{4{v[7]}}, v};
    endfunction

    function automatic logic on_stage(input logic signed [11:0] xv);
        return (xv >= XMIN) && (xv <= XMAX);
    endfunction

    assign key_l = (keycode_1 == KEY_LEFT)  || (keycode_2 == KEY_LEFT)  ||
                   (keycode_3 == KEY_LEFT)  || (keycode_4 == KEY_LEFT);
    assign key_r = (keycode_1 == KEY_RIGHT) || (keycode_2 == KEY_RIGHT) ||
                   (keycode_3 == KEY_RIGHT) || (keycode_4 == KEY_RIGHT);
    assign key_j = (keycode_1 == KEY_JUMP)  || (keycode_2 == KEY_JUMP)  ||
                   (keycode_3 == KEY_JUMP)  || (keycode_4 == KEY_JUMP);

    always_comb begin
        vx_cmd = 8'sd0;
        if (key_r && !key_l)      vx_cmd = WALK;
        else if (key_l && !key_r) vx_cmd = -WALK;
    end

    // Knockback grows with accumulated damage, saturating at KB_MAX.
    assign kb_sum   = 13'(KB_BASE) + 13'(hp >> KB_SHIFT);
    assign kb_mag   = (kb_sum > 13'(KB_MAX)) ? 8'(KB_MAX) : 8'(kb_sum);
    assign x_ge_opp = x_q >= $signed({2'b00, opp_x});

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        vy_d        = vy_q;
        kb_d        = kb_q;
        air_jumps_d = air_jumps_q;
        facing_d    = facing_q;
        jump_prev_d = jump_prev_q;
        hit_prev_d  = hit_prev_q;
        death_d     = death_q;
        on_ground_d = on_ground_q;
        cnt_d       = cnt_q;
        st_c        = state_q;
        vy_c        = vy_q;
        kb_c        = kb_q;
        aj_c        = air_jumps_q;
        x_nx        = x_q;
        y_nx        = y_q;

        if (!enable) begin
            state_d     = IDLE;
            x_d         = SPX;
            y_d         = SPY;
            vy_d        = 8'sd0;
            kb_d        = 8'sd0;
            air_jumps_d = 1'b1;
            facing_d    = 1'b1;
            jump_prev_d = 1'b0;
            hit_prev_d  = 1'b0;
            death_d     = 1'b0;
            on_ground_d = 1'b0;
            cnt_d       = '0;
        end else if (frame_tick) begin
            jump_prev_d = key_j;
            hit_prev_d  = hit_in;
            case (state_q)
                IDLE: begin
                    state_d = AIR;
                    vy_d    = 8'sd0;
                end
                AIR, GROUND: begin
                    if (vx_cmd != 8'sd0) facing_d = (vx_cmd > 8'sd0);
                    if (hit_in && !hit_prev_q) begin
                        kb_c = x_ge_opp ? kb_mag : -kb_mag;
                        vy_c = -$signed({1'b0, kb_mag[7:1]});
                        st_c = AIR;
                    end else if (key_j && !jump_prev_q && (st_c == GROUND || aj_c)) begin
                        if (st_c == AIR) aj_c = 1'b0;
                        vy_c = -JUMP;
                        st_c = AIR;
                    end
                    // Vertical step integrates the post-gravity velocity.
                    if (st_c == AIR) vy_c = (vy_c >= FALL) ? FALL : vy_c + 8'sd1;
                    x_nx = x_q + sx(vx_cmd) + sx(kb_c);
                    y_nx = y_q + sx(vy_c);
                    if (kb_c > 8'sd0)      kb_c = kb_c - 8'sd1;
                    else if (kb_c < 8'sd0) kb_c = kb_c + 8'sd1;
                    if (st_c == AIR && vy_c >= 8'sd0 && y_q <= GY && y_nx >= GY && on_stage(x_nx)) begin
                        y_nx = GY;
                        vy_c = 8'sd0;
                        st_c = GROUND;
                        aj_c = 1'b1;
                    end else if (st_c == GROUND && !on_stage(x_nx)) begin
                        st_c = AIR;
                        vy_c = 8'sd0;
                    end
                    if (x_nx < 12'sd0 || x_nx > XLIM || y_nx > YLIM) begin
                        state_d     = DEAD;
                        x_d         = SPX;
                        y_d         = SPY;
                        vy_d        = 8'sd0;
                        kb_d        = 8'sd0;
                        death_d     = 1'b1;
                        on_ground_d = 1'b0;
                        cnt_d       = '0;
                    end else begin
                        state_d     = st_c;
                        x_d         = x_nx;
                        y_d         = y_nx;
                        vy_d        = vy_c;
                        kb_d        = kb_c;
                        air_jumps_d = aj_c;
                        on_ground_d = (st_c == GROUND);
                    end
                end
                DEAD: begin
                    if (cnt_q == CLAST) begin
                        state_d     = AIR;
                        x_d         = SPX;
                        y_d         = SPY;
                        vy_d        = 8'sd0;
                        kb_d        = 8'sd0;
                        air_jumps_d = 1'b1;
                        death_d     = 1'b0;
                        cnt_d       = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            x_q         <= SPX;
            y_q         <= SPY;
            vy_q        <= 8'sd0;
            kb_q        <= 8'sd0;
            air_jumps_q <= 1'b1;
            facing_q    <= 1'b1;
            jump_prev_q <= 1'b0;
            hit_prev_q  <= 1'b0;
            death_q     <= 1'b0;
            on_ground_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            vy_q        <= vy_d;
            kb_q        <= kb_d;
            air_jumps_q <= air_jumps_d;
            facing_q    <= facing_d;
            jump_prev_q <= jump_prev_d;
            hit_prev_q  <= hit_prev_d;
            death_q     <= death_d;
            on_ground_q <= on_ground_d;
            cnt_q       <= cnt_d;
        end
    end

    assign pos_x     = x_q[9:0];
    assign pos_y     = y_q[9:0];
    assign death     = death_q;
    assign on_ground = on_ground_q;
    assign facing    = facing_q;
endmodule

// File: tb/tb_fighter_motion.sv
// Bench for fighter_motion: vector table plus hand-written enable/reset sequences,
// expectations queued on a scoreboard and compared after each stimulus step.
module tb_fighter_motion;
    localparam logic [7:0] KL = 8'h04;
    localparam logic [7:0] KR = 8'h07;
    localparam logic [7:0] KJ = 8'h1A;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        frame_tick = 1'b0;
    logic        enable = 1'b0;
    logic [7:0]  keycode_1 = 8'h00, keycode_2 = 8'h00, keycode_3 = 8'h00, keycode_4 = 8'h00;
    logic [11:0] hp = 12'd0;
    logic        hit_in = 1'b0;
    logic [9:0]  opp_x = 10'd600;
    logic [9:0]  pos_x, pos_y;
    logic        death, on_ground, facing;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fighter_motion dut (
        .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick), .enable(enable),
        .keycode_1(keycode_1), .keycode_2(keycode_2), .keycode_3(keycode_3), .keycode_4(keycode_4),
        .hp(hp), .hit_in(hit_in), .opp_x(opp_x),
        .pos_x(pos_x), .pos_y(pos_y), .death(death), .on_ground(on_ground), .facing(facing)
    );

    typedef struct { string nm; int x; int y; bit d; bit g; bit f; } exp_t;
    typedef struct {
        string nm; bit rs; bit l; bit r; bit j; bit h; int n; int opp; int hpv;
        int ex; int ey; bit ed; bit eg; bit ef;
    } vec_t;

    exp_t sb[$];
    vec_t tv[$];

    function automatic vec_t V(string nm, bit rs, bit l, bit r, bit j, bit h, int n,
                               int opp, int hpv, int ex, int ey, bit ed, bit eg, bit ef);
        vec_t v;
        v.nm = nm; v.rs = rs; v.l = l; v.r = r; v.j = j; v.h = h; v.n = n;
        v.opp = opp; v.hpv = hpv; v.ex = ex; v.ey = ey; v.ed = ed; v.eg = eg; v.ef = ef;
        return v;
    endfunction

    task automatic cmp(input string nm, input string fld, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s.%s: got %0d, expected %0d", nm, fld, got, want);
        end
    endtask

    task automatic expect_out(input string nm, input int x, input int y, input bit d, input bit g, input bit f);
        exp_t e;
        e.nm = nm; e.x = x; e.y = y; e.d = d; e.g = g; e.f = f;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: queue empty, got nothing, expected an entry");
        end else begin
            e = sb.pop_front();
            cmp(e.nm, "pos_x", int'(pos_x), e.x);
            cmp(e.nm, "pos_y", int'(pos_y), e.y);
            cmp(e.nm, "death", int'(death), int'(e.d));
            cmp(e.nm, "on_ground", int'(on_ground), int'(e.g));
            cmp(e.nm, "facing", int'(facing), int'(e.f));
        end
    endtask

    // Keys land in different keycode slots to exercise the any-slot match.
    task automatic set_keys(input bit l, input bit r, input bit j);
        keycode_1 = l ? KL : 8'h00;
        keycode_2 = j ? KJ : 8'h2C;
        keycode_3 = 8'h00;
        keycode_4 = r ? KR : 8'h00;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk) frame_tick = 1'b1;
            @(negedge clk) frame_tick = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic do_spawn();
        set_keys(1'b0, 1'b0, 1'b0);
        hit_in = 1'b0;
        enable = 1'b0;
        @(negedge clk) reset_n = 1'b0;
        @(negedge clk) begin reset_n = 1'b1; enable = 1'b1; end
        tick(40);
    endtask

    task automatic run_vec(input vec_t v);
        opp_x = 10'(v.opp);
        hp    = 12'(v.hpv);
        expect_out(v.nm, v.ex, v.ey, v.ed, v.eg, v.ef);
        if (v.rs) begin
            do_spawn();
        end else begin
            set_keys(v.l, v.r, v.j);
            hit_in = v.h;
            tick(v.n);
        end
        check_out();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "timeout");
    end

    initial begin
        // Walk, jump, landing
        tv.push_back(V("walk_r",   0, 0,1,0,0, 10, 600,0, 220,380, 0,1,1));
        tv.push_back(V("walk_lr",  0, 1,1,0,0,  3, 600,0, 220,380, 0,1,1));
        tv.push_back(V("walk_l",   0, 1,0,0,0, 10, 600,0, 200,380, 0,1,0));
        tv.push_back(V("idle_gnd", 0, 0,0,0,0,  2, 600,0, 200,380, 0,1,0));
        tv.push_back(V("jump1",    0, 0,0,1,0,  1, 600,0, 200,369, 0,0,0));
        tv.push_back(V("rel1",     0, 0,0,0,0,  1, 600,0, 200,359, 0,0,0));
        tv.push_back(V("jump2",    0, 0,0,1,0,  1, 600,0, 200,348, 0,0,0));
        tv.push_back(V("rel2",     0, 0,0,0,0,  1, 600,0, 200,338, 0,0,0));
        tv.push_back(V("jump3_ign",0, 0,0,1,0,  1, 600,0, 200,329, 0,0,0));
        tv.push_back(V("fall_pre", 0, 0,0,0,0, 23, 600,0, 200,377, 0,0,0));
        tv.push_back(V("land",     0, 0,0,0,0,  1, 600,0, 200,380, 0,1,0));
        // Knockback away from opponent, drift and landing
        tv.push_back(V("spawn_a",  1, 0,0,0,0,  0, 150,80, 200,380, 0,1,1));
        tv.push_back(V("hit",      0, 0,0,0,1,  1, 150,80, 214,374, 0,0,1));
        tv.push_back(V("kb_drift", 0, 0,0,0,1, 11, 150,80, 302,374, 0,0,1));
        tv.push_back(V("kb_land",  0, 0,0,0,1,  1, 150,80, 304,380, 0,1,1));
        // Hit beats jump in the same frame; negative knockback direction
        tv.push_back(V("spawn_b",  1, 0,0,0,0,  0, 400,100, 200,380, 0,1,1));
        tv.push_back(V("hit_jump", 0, 0,0,1,1,  1, 400,100, 184,373, 0,0,1));
        // Knockback cap, x equal to opponent counts as push right
        tv.push_back(V("spawn_c",  1, 0,0,0,0,  0, 200,4000, 200,380, 0,1,1));
        tv.push_back(V("hit_cap",  0, 0,0,0,1,  1, 200,4000, 224,369, 0,0,1));
        // Walk off the left edge, fall out, respawn
        tv.push_back(V("spawn_d",  1, 0,0,0,0,  0, 600,0, 200,380, 0,1,1));
        tv.push_back(V("to_82",    0, 1,0,0,0, 59, 600,0,  82,380, 0,1,0));
        tv.push_back(V("edge_80",  0, 1,0,0,0,  1, 600,0,  80,380, 0,1,0));
        tv.push_back(V("walk_off", 0, 1,0,0,0,  1, 600,0,  78,380, 0,0,0));
        tv.push_back(V("falling",  0, 0,0,0,0, 15, 600,0,  78,472, 0,0,0));
        tv.push_back(V("ring_out", 0, 0,0,0,0,  1, 600,0, 200,100, 1,0,0));
        tv.push_back(V("dead_58",  0, 0,0,0,0, 58, 600,0, 200,100, 1,0,0));
        tv.push_back(V("dead_59",  0, 0,0,0,0,  1, 600,0, 200,100, 1,0,0));
        tv.push_back(V("respawn",  0, 0,0,0,0,  1, 600,0, 200,100, 0,0,0));
        tv.push_back(V("resp_fall",0, 0,0,0,0,  1, 600,0, 200,101, 0,0,0));
        tv.push_back(V("air_right",0, 0,1,0,0,  1, 600,0, 202,103, 0,0,1));

        // Reset state and first landing
        #1 reset_n = 1'b0;
        expect_out("reset", 200, 100, 1'b0, 1'b0, 1'b1);
        #11 check_out();
        @(negedge clk) begin reset_n = 1'b1; enable = 1'b1; end
        expect_out("fall_39", 200, 376, 1'b0, 1'b0, 1'b1);
        tick(39);
        check_out();
        expect_out("land_40", 200, 380, 1'b0, 1'b1, 1'b1);
        tick(1);
        check_out();

        for (int i = 0; i < tv.size(); i++) run_vec(tv[i]);

        // enable low mid-air: back to spawn on the very next clock
        set_keys(1'b0, 1'b0, 1'b0);
        expect_out("en_low", 200, 100, 1'b0, 1'b0, 1'b1);
        @(negedge clk) enable = 1'b0;
        @(negedge clk);
        check_out();
        expect_out("idle_hold", 200, 100, 1'b0, 1'b0, 1'b1);
        tick(1);
        check_out();
        enable = 1'b1;
        expect_out("idle_exit", 200, 100, 1'b0, 1'b0, 1'b1);
        tick(1);
        check_out();
        expect_out("idle_fall", 200, 101, 1'b0, 1'b0, 1'b1);
        tick(1);
        check_out();

        // Asynchronous reset in the middle of DEAD
        run_vec(V("spawn_e",   1, 0,0,0,0,  0, 600,0, 200,380, 0,1,1));
        run_vec(V("off_again", 0, 1,0,0,0, 61, 600,0,  78,380, 0,0,0));
        run_vec(V("die_again", 0, 0,0,0,0, 16, 600,0, 200,100, 1,0,0));
        run_vec(V("dead_mid",  0, 0,0,0,0, 10, 600,0, 200,100, 1,0,0));
        expect_out("rst_dead", 200, 100, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1 check_out();
        @(negedge clk) reset_n = 1'b1;
        expect_out("post_rst", 200, 100, 1'b0, 1'b0, 1'b1);
        tick(1);
        check_out();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
